scariv_csu_pipe: RTL and testbench
==================================

Name: scariv_csu_pipe

Overview:
- Execution pipeline for CSR (CSU) instructions; sits directly downstream of the CSU issue entries.
- Accepts one picked CSU instruction, reads the CSR, computes the new value, writes rd and returns a done/exception report to the ROB.
- CSR ops are serializing, so at most one op is in flight. A writing op holds the pipe until it commits.

Parameters:
XLEN, 64, data width
RNID_W, 7, physical register id width
CMT_ID_W, 6, ROB commit id width
GRP_W, 4, one-hot group id width
CSR_ADDR_W, 12, CSR address width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_iss_valid  in  1  issue request from picked entry
o_iss_ready  out  1  pipe can accept
i_iss_cmt_id  in  CMT_ID_W  ROB id
i_iss_grp_id  in  GRP_W  group id (one-hot)
i_iss_op  in  2  0=RW 1=RS 2=RC 3=reserved
i_iss_csr_addr  in  CSR_ADDR_W  CSR address
i_iss_rs1_data  in  XLEN  rs1 or zimm operand
i_iss_wr_en  in  1  op writes CSR (RS/RC with rs1!=0, or RW)
i_iss_rd_valid  in  1  rd write required
i_iss_rd_rnid  in  RNID_W  rd physical id
o_csr_rd_addr  out  CSR_ADDR_W  CSR read address
i_csr_rd_data  in  XLEN  CSR read data, valid in cycle after address
i_csr_rd_illegal  in  1  CSR illegal/privilege fault, same timing as data
o_csr_wr_valid  out  1  CSR write strobe
o_csr_wr_addr  out  CSR_ADDR_W  write address
o_csr_wr_data  out  XLEN  write data
o_phy_wr_valid  out  1  rd writeback
o_phy_wr_rnid  out  RNID_W  rd id
o_phy_wr_data  out  XLEN  old CSR value
o_done_valid  out  1  ROB completion report
o_done_cmt_id  out  CMT_ID_W  id
o_done_grp_id  out  GRP_W  group
o_done_except  out  1  illegal-instruction exception
i_commit_valid  in  1  ROB commit
i_commit_cmt_id  in  CMT_ID_W  committed id
i_flush  in  1  pipeline flush (commit flush or branch kill)

Behaviour:
- Reset: state IDLE; o_iss_ready=1; all other outputs 0.
- FSM:
  - IDLE: o_iss_ready=1. On i_iss_valid, latch all fields and go to EX1.
  - EX1: drive o_csr_rd_addr from the latched address.
  - EX2: capture i_csr_rd_data and i_csr_rd_illegal. Compute new = RW: rs1; RS: old|rs1; RC: old&~rs1.
    - Assert o_done_valid for one cycle with the latched ids. o_done_except = illegal, or op==3.
    - If no exception and rd_valid: o_phy_wr_valid=1, data=old. No rd write on exception.
    - Next state: WAIT_CMT if wr_en and no exception; otherwise IDLE.
  - WAIT_CMT: on i_commit_valid with i_commit_cmt_id==latched cmt_id, pulse o_csr_wr_valid with the new value (latched in EX2), then go to IDLE.
- o_iss_ready=0 in EX1, EX2 and WAIT_CMT. An issue arriving while not ready is ignored; the issue entry must hold it.
- Latency: issue→done = 2 cycles after acceptance. Commit→CSR write = same cycle as the matching commit (combinational strobe, registered data).
- i_flush:
  - Any state returns to IDLE next cycle; no done, phy or CSR write from the killed op.
  - A flush in the same cycle as EX2 suppresses done and phy write.
  - A flush in WAIT_CMT together with a matching commit: the commit wins (the write occurs), because a committed op cannot be flushed.
  - Flush together with an issue in IDLE: the issue is dropped.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no partial CSR write.
- Widths: all arithmetic is bitwise; no carries.

Optional Feature:
- Macro SCARIV_CSU_PERF_CNT_EN.
  - Defined: adds outputs o_perf_issue_cnt[31:0] and o_perf_wait_cnt[31:0].
    - o_perf_issue_cnt increments on each accepted issue.
    - o_perf_wait_cnt increments on each cycle spent in WAIT_CMT.
    - Both counters wrap at 2^32, reset to 0 and are unaffected by flush.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- scariv_pkg: csu_op_t enum (RW/RS/RC/RSV) and csu_pipe_state_t (IDLE/EX1/EX2/WAIT_CMT).
- Reuse existing cmt_id_t, grp_id_t and rnid_t types.
- One sub-module: scariv_csu_alu, the combinational new-value computation.

Test Plan:
- RS op, rs1=0x0F, CSR old=0xF0, wr_en=1, rd rnid=5 → cycle+2: phy_wr rnid 5 data 0xF0, done; after commit of same cmt_id, csr_wr data 0xFF.
- RC op, rs1=0x3, old=0x7, wr_en=0 → done and phy_wr 0x7, no CSR write, back to IDLE, o_iss_ready=1 at cycle+3.
- i_csr_rd_illegal=1 → done with except=1, no phy_wr, no csr_wr, no WAIT_CMT.
- Flush asserted in EX2 → no done, no phy_wr; next-cycle issue accepted.
- WAIT_CMT with a non-matching commit id, then flush → no csr_wr ever; flush coincident with matching commit → csr_wr occurs.
- Second issue held valid during busy → accepted only in the first IDLE cycle; with SCARIV_CSU_PERF_CNT_EN defined, issue_cnt=2.

Source files
------------

// File: rtl/scariv_pkg.sv
// rtl/scariv_pkg.sv - shared widths, ids and CSU enums for the scariv core slice
package scariv_pkg;

    localparam int SCARIV_XLEN       = 64;
    localparam int SCARIV_RNID_W     = 7;
    localparam int SCARIV_CMT_ID_W   = 6;
    localparam int SCARIV_GRP_W      = 4;
    localparam int SCARIV_CSR_ADDR_W = 12;

    typedef logic [SCARIV_CMT_ID_W-1:0] cmt_id_t;
    typedef logic [SCARIV_GRP_W-1:0]    grp_id_t;
    typedef logic [SCARIV_RNID_W-1:0]   rnid_t;

    typedef enum logic [1:0] {
        CSU_RW  = 2'd0,
        CSU_RS  = 2'd1,
        CSU_RC  = 2'd2,
        CSU_RSV = 2'd3
    } csu_op_t;

    typedef enum logic [1:0] {
        CSU_IDLE     = 2'd0,
        CSU_EX1      = 2'd1,
        CSU_EX2      = 2'd2,
        CSU_WAIT_CMT = 2'd3
    } csu_pipe_state_t;

    // The reserved encoding always raises an illegal-instruction exception.
    function automatic logic csu_op_is_rsv(input csu_op_t op);
        return op == CSU_RSV;
    endfunction

endpackage

// File: rtl/scariv_csu_alu.sv
// rtl/scariv_csu_alu.sv - combinational CSR new-value computation (RW/RS/RC)
module scariv_csu_alu
    import scariv_pkg::*;
#(
    parameter int XLEN = SCARIV_XLEN
) (
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs1,
    output logic [XLEN-1:0] o_new
);

    always_comb begin
        o_new = i_old;
        case (csu_op_t'(i_op))
            CSU_RW:  o_new = i_rs1;
            CSU_RS:  o_new = i_old | i_rs1;
            CSU_RC:  o_new = i_old & ~i_rs1;
            default: o_new = i_old;
        endcase
    end

endmodule

// File: rtl/scariv_csu_pipe.sv
// rtl/scariv_csu_pipe.sv - serializing CSR execution pipe: read, modify, rd writeback, commit-time write
// Optional perf counters enabled by SCARIV_CSU_PERF_CNT_EN.
module scariv_csu_pipe
    import scariv_pkg::*;
#(
    parameter int XLEN       = SCARIV_XLEN,
    parameter int RNID_W     = SCARIV_RNID_W,
    parameter int CMT_ID_W   = SCARIV_CMT_ID_W,
    parameter int GRP_W      = SCARIV_GRP_W,
    parameter int CSR_ADDR_W = SCARIV_CSR_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic                  i_iss_valid,
    output logic                  o_iss_ready,
    input  logic [CMT_ID_W-1:0]   i_iss_cmt_id,
    input  logic [GRP_W-1:0]      i_iss_grp_id,
    input  logic [1:0]            i_iss_op,
    input  logic [CSR_ADDR_W-1:0] i_iss_csr_addr,
    input  logic [XLEN-1:0]       i_iss_rs1_data,
    input  logic                  i_iss_wr_en,
    input  logic                  i_iss_rd_valid,
    input  logic [RNID_W-1:0]     i_iss_rd_rnid,

    output logic [CSR_ADDR_W-1:0] o_csr_rd_addr,
    input  logic [XLEN-1:0]       i_csr_rd_data,
    input  logic                  i_csr_rd_illegal,

    output logic                  o_csr_wr_valid,
    output logic [CSR_ADDR_W-1:0] o_csr_wr_addr,
    output logic [XLEN-1:0]       o_csr_wr_data,

    output logic                  o_phy_wr_valid,
    output logic [RNID_W-1:0]     o_phy_wr_rnid,
    output logic [XLEN-1:0]       o_phy_wr_data,

    output logic                  o_done_valid,
    output logic [CMT_ID_W-1:0]   o_done_cmt_id,
    output logic [GRP_W-1:0]      o_done_grp_id,
    output logic                  o_done_except,

    input  logic                  i_commit_valid,
    input  logic [CMT_ID_W-1:0]   i_commit_cmt_id,
`ifdef SCARIV_CSU_PERF_CNT_EN
    output logic [31:0]           o_perf_issue_cnt,
    output logic [31:0]           o_perf_wait_cnt,
`endif
    input  logic                  i_flush
);

    csu_pipe_state_t state_q, state_d;

    logic [CMT_ID_W-1:0]   cmt_id_q;
    logic [GRP_W-1:0]      grp_id_q;
    csu_op_t               op_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       rs1_q;
    logic                  wr_en_q;
    logic                  rd_valid_q;
    logic [RNID_W-1:0]     rnid_q;
    logic [XLEN-1:0]       new_q;

    logic                  accept;
    logic                  ex2_except;
    logic                  cmt_match;
    logic [XLEN-1:0]       alu_new;

    assign accept     = (state_q == CSU_IDLE) && i_iss_valid && !i_flush;
    assign ex2_except = i_csr_rd_illegal || csu_op_is_rsv(op_q);
    assign cmt_match  = i_commit_valid && (i_commit_cmt_id == cmt_id_q);

    scariv_csu_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_op  (op_q),
        .i_old (i_csr_rd_data),
        .i_rs1 (rs1_q),
        .o_new (alu_new)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= CSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cmt_id_q   <= '0;
            grp_id_q   <= '0;
            op_q       <= CSU_RW;
            addr_q     <= '0;
            rs1_q      <= '0;
            wr_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rnid_q     <= '0;
            new_q      <= '0;
        end else begin
            if (accept) begin
                cmt_id_q   <= i_iss_cmt_id;
                grp_id_q   <= i_iss_grp_id;
                op_q       <= csu_op_t'(i_iss_op);
                addr_q     <= i_iss_csr_addr;
                rs1_q      <= i_iss_rs1_data;
                wr_en_q    <= i_iss_wr_en;
                rd_valid_q <= i_iss_rd_valid;
                rnid_q     <= i_iss_rd_rnid;
            end
            // Held until commit so the CSR write does not depend on re-reading the CSR.
            if (state_q == CSU_EX2) begin
                new_q <= alu_new;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        o_iss_ready    = 1'b0;
        o_csr_rd_addr  = '0;
        o_csr_wr_valid = 1'b0;
        o_csr_wr_addr  = '0;
        o_csr_wr_data  = '0;
        o_phy_wr_valid = 1'b0;
        o_phy_wr_rnid  = '0;
        o_phy_wr_data  = '0;
        o_done_valid   = 1'b0;
        o_done_cmt_id  = '0;
        o_done_grp_id  = '0;
        o_done_except  = 1'b0;

        case (state_q)
            CSU_IDLE: begin
                o_iss_ready = 1'b1;
                if (accept) begin
                    state_d = CSU_EX1;
                end
            end
            CSU_EX1: begin
                o_csr_rd_addr = addr_q;
                state_d       = i_flush ? CSU_IDLE : CSU_EX2;
            end
            CSU_EX2: begin
                if (!i_flush) begin
                    o_done_valid  = 1'b1;
                    o_done_cmt_id = cmt_id_q;
                    o_done_grp_id = grp_id_q;
                    o_done_except = ex2_except;
                    if (rd_valid_q && !ex2_except) begin
                        o_phy_wr_valid = 1'b1;
                        o_phy_wr_rnid  = rnid_q;
                        o_phy_wr_data  = i_csr_rd_data;
                    end
                end
                state_d = (!i_flush && wr_en_q && !ex2_except) ? CSU_WAIT_CMT : CSU_IDLE;
            end
            CSU_WAIT_CMT: begin
                // A committed op can no longer be killed, so commit takes priority over flush.
                if (cmt_match) begin
                    o_csr_wr_valid = 1'b1;
                    o_csr_wr_addr  = addr_q;
                    o_csr_wr_data  = new_q;
                    state_d        = CSU_IDLE;
                end else if (i_flush) begin
                    state_d = CSU_IDLE;
                end
            end
            default: state_d = CSU_IDLE;
        endcase
    end

`ifdef SCARIV_CSU_PERF_CNT_EN
    logic [31:0] perf_issue_cnt_q;
    logic [31:0] perf_wait_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_issue_cnt_q <= '0;
            perf_wait_cnt_q  <= '0;
        end else begin
            if (accept) begin
                perf_issue_cnt_q <= perf_issue_cnt_q + 32'd1;
            end
            if (state_q == CSU_WAIT_CMT) begin
                perf_wait_cnt_q <= perf_wait_cnt_q + 32'd1;
            end
        end
    end

    assign o_perf_issue_cnt = perf_issue_cnt_q;
    assign o_perf_wait_cnt  = perf_wait_cnt_q;
`endif

endmodule

// File: tb/tb_scariv_csu_pipe.sv
// tb/tb_scariv_csu_pipe.sv - directed and randomized checks of scariv_csu_pipe against a CSR-file reference model
module tb_scariv_csu_pipe;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [5:0]  iss_cmt_id;
    logic [3:0]  iss_grp_id;
    logic [1:0]  iss_op;
    logic [11:0] iss_addr;
    logic [63:0] iss_rs1;
    logic        iss_wr_en;
    logic        iss_rd_valid;
    logic [6:0]  iss_rnid;
    logic [11:0] csr_rd_addr;
    logic [63:0] csr_rd_data;
    logic        csr_rd_illegal;
    logic        csr_wr_valid;
    logic [11:0] csr_wr_addr;
    logic [63:0] csr_wr_data;
    logic        phy_valid;
    logic [6:0]  phy_rnid;
    logic [63:0] phy_data;
    logic        done_valid;
    logic [5:0]  done_cmt;
    logic [3:0]  done_grp;
    logic        done_except;
    logic        commit_valid;
    logic [5:0]  commit_id;
    logic        flush;
`ifdef SCARIV_CSU_PERF_CNT_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_wait;
`endif

    scariv_csu_pipe dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_iss_valid      (iss_valid),
        .o_iss_ready      (iss_ready),
        .i_iss_cmt_id     (iss_cmt_id),
        .i_iss_grp_id     (iss_grp_id),
        .i_iss_op         (iss_op),
        .i_iss_csr_addr   (iss_addr),
        .i_iss_rs1_data   (iss_rs1),
        .i_iss_wr_en      (iss_wr_en),
        .i_iss_rd_valid   (iss_rd_valid),
        .i_iss_rd_rnid    (iss_rnid),
        .o_csr_rd_addr    (csr_rd_addr),
        .i_csr_rd_data    (csr_rd_data),
        .i_csr_rd_illegal (csr_rd_illegal),
        .o_csr_wr_valid   (csr_wr_valid),
        .o_csr_wr_addr    (csr_wr_addr),
        .o_csr_wr_data    (csr_wr_data),
        .o_phy_wr_valid   (phy_valid),
        .o_phy_wr_rnid    (phy_rnid),
        .o_phy_wr_data    (phy_data),
        .o_done_valid     (done_valid),
        .o_done_cmt_id    (done_cmt),
        .o_done_grp_id    (done_grp),
        .o_done_except    (done_except),
        .i_commit_valid   (commit_valid),
        .i_commit_cmt_id  (commit_id),
`ifdef SCARIV_CSU_PERF_CNT_EN
        .o_perf_issue_cnt (perf_issue),
        .o_perf_wait_cnt  (perf_wait),
`endif
        .i_flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file device: registered read, written only by the DUT strobe (or preload).
    logic [63:0] csr_dev [16];
    logic [63:0] csr_ref [16];
    logic [15:0] ill_mask;
    logic        preload;

    always @(posedge clk) begin
        csr_rd_data    <= csr_dev[csr_rd_addr[3:0]];
        csr_rd_illegal <= ill_mask[csr_rd_addr[3:0]];
        if (preload) begin
            for (int i = 0; i < 16; i++) csr_dev[i] <= csr_ref[i];
        end else if (csr_wr_valid) begin
            csr_dev[csr_wr_addr[3:0]] <= csr_wr_data;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_issue = 0;
    int exp_wait = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_new(input int op, input logic [63:0] old, input logic [63:0] rs1);
        case (op)
            0:       return rs1;
            1:       return old | rs1;
            2:       return old & ~rs1;
            default: return old;
        endcase
    endfunction

    task automatic drive_issue(input int op, input logic [11:0] addr, input logic [63:0] rs1,
                               input bit wr_en, input bit rd_valid, input logic [6:0] rnid,
                               input logic [5:0] cmt, input logic [3:0] grp);
        iss_valid    = 1'b1;
        iss_op       = 2'(op);
        iss_addr     = addr;
        iss_rs1      = rs1;
        iss_wr_en    = wr_en;
        iss_rd_valid = rd_valid;
        iss_rnid     = rnid;
        iss_cmt_id   = cmt;
        iss_grp_id   = grp;
    endtask

    // wait_kind: 0 matching commit, 1 non-matching commits then flush, 2 flush with matching commit
    task automatic run_op(input int op, input logic [11:0] addr, input logic [63:0] rs1,
                          input bit wr_en, input bit rd_valid, input logic [6:0] rnid,
                          input logic [5:0] cmt, input logic [3:0] grp,
                          input bit flush_ex2, input int wait_kind);
        logic [63:0] old;
        logic [63:0] nv;
        bit          exc;
        bit          phy_exp;
        bit          to_wait;
        int          idx;
        idx     = int'(addr[3:0]);
        old     = csr_ref[idx];
        exc     = ill_mask[idx] || (op == 3);
        nv      = ref_new(op, old, rs1);
        phy_exp = !flush_ex2 && !exc && rd_valid;
        to_wait = !flush_ex2 && wr_en && !exc;

        @(negedge clk);
        commit_valid = 1'b0;
        flush        = 1'b0;
        drive_issue(op, addr, rs1, wr_en, rd_valid, rnid, cmt, grp);
        #1 chk("idle_ready", iss_ready, 1);
        exp_issue++;

        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        chk("ex1_ready", iss_ready, 0);
        chk("ex1_rd_addr", csr_rd_addr, addr);
        chk("ex1_no_done", done_valid, 0);

        @(negedge clk);
        flush = flush_ex2;
        #1;
        chk("ex2_done", done_valid, !flush_ex2);
        if (!flush_ex2) begin
            chk("ex2_cmt", done_cmt, cmt);
            chk("ex2_grp", done_grp, grp);
            chk("ex2_except", done_except, exc);
        end
        chk("ex2_phy_valid", phy_valid, phy_exp);
        if (phy_exp) begin
            chk("ex2_phy_rnid", phy_rnid, rnid);
            chk("ex2_phy_data", phy_data, old);
        end

        @(negedge clk);
        flush = 1'b0;
        if (to_wait) begin
            case (wait_kind)
                0: begin
                    commit_valid = 1'b1;
                    commit_id    = cmt;
                    #1;
                    chk("wr_valid", csr_wr_valid, 1);
                    chk("wr_addr", csr_wr_addr, addr);
                    chk("wr_data", csr_wr_data, nv);
                    exp_wait++;
                    csr_ref[idx] = nv;
                    @(negedge clk);
                    commit_valid = 1'b0;
                    #1 chk("post_cmt_ready", iss_ready, 1);
                end
                1: begin
                    for (int k = 0; k < 3; k++) begin
                        commit_valid = 1'b1;
                        commit_id    = cmt ^ 6'h1;
                        #1;
                        chk("nomatch_no_wr", csr_wr_valid, 0);
                        chk("wait_ready", iss_ready, 0);
                        exp_wait++;
                        @(negedge clk);
                    end
                    commit_valid = 1'b0;
                    flush        = 1'b1;
                    #1 chk("flush_wait_no_wr", csr_wr_valid, 0);
                    exp_wait++;
                    @(negedge clk);
                    flush        = 1'b0;
                    commit_valid = 1'b1;
                    commit_id    = cmt;
                    #1;
                    chk("killed_ready", iss_ready, 1);
                    chk("killed_no_wr", csr_wr_valid, 0);
                end
                default: begin
                    flush        = 1'b1;
                    commit_valid = 1'b1;
                    commit_id    = cmt;
                    #1;
                    chk("flushcmt_wr_valid", csr_wr_valid, 1);
                    chk("flushcmt_wr_data", csr_wr_data, nv);
                    exp_wait++;
                    csr_ref[idx] = nv;
                end
            endcase
        end else begin
            #1;
            chk("back_idle_ready", iss_ready, 1);
            chk("back_idle_no_wr", csr_wr_valid, 0);
        end
    endtask

    initial begin
        logic [11:0] a_addr;
        logic [11:0] b_addr;
        logic [11:0] r_addr;
        rst_n        = 1'b0;
        preload      = 1'b1;
        iss_valid    = 1'b0;
        commit_valid = 1'b0;
        commit_id    = '0;
        flush        = 1'b0;
        drive_issue(0, '0, '0, 0, 0, '0, '0, '0);
        iss_valid    = 1'b0;
        ill_mask     = 16'h8000;
        for (int i = 0; i < 16; i++) csr_ref[i] = {$urandom, $urandom};
        csr_ref[1] = 64'hF0;
        csr_ref[2] = 64'h7;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", iss_ready, 1);
        chk("rst_done", done_valid, 0);
        chk("rst_phy", phy_valid, 0);
        chk("rst_csr_wr", csr_wr_valid, 0);
        chk("rst_rd_addr", csr_rd_addr, 0);
        @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b1;

        // RS: 0xF0 | 0x0F -> 0xFF, rd gets old 0xF0
        run_op(1, 12'h301, 64'h0F, 1, 1, 7'd5, 6'd10, 4'b0001, 0, 0);
        // RC without write
        run_op(2, 12'h342, 64'h3, 0, 1, 7'd9, 6'd11, 4'b0010, 0, 0);
        // illegal CSR
        run_op(0, 12'h00F, 64'h1234, 1, 1, 7'd3, 6'd12, 4'b0100, 0, 0);
        // reserved op
        run_op(3, 12'h003, 64'h55, 1, 1, 7'd4, 6'd13, 4'b1000, 0, 0);
        // flush in EX2
        run_op(0, 12'h004, 64'hABCD, 1, 1, 7'd6, 6'd14, 4'b0001, 1, 0);
        // non-matching commit then flush; then flush coincident with matching commit
        run_op(0, 12'h005, 64'h77, 1, 1, 7'd7, 6'd15, 4'b0010, 0, 1);
        run_op(1, 12'h006, 64'h300, 1, 0, 7'd8, 6'd16, 4'b0100, 0, 2);

        // second issue held valid while busy
        a_addr = 12'h107;
        b_addr = 12'h208;
        @(negedge clk);
        commit_valid = 1'b0;
        flush        = 1'b0;
        drive_issue(0, a_addr, 64'h99, 1, 1, 7'd20, 6'd30, 4'b0001);
        #1 chk("hold_a_ready", iss_ready, 1);
        exp_issue++;
        @(negedge clk);
        drive_issue(2, b_addr, 64'hF, 0, 1, 7'd21, 6'd31, 4'b0010);
        #1;
        chk("hold_ex1_ready", iss_ready, 0);
        chk("hold_ex1_addr", csr_rd_addr, a_addr);
        @(negedge clk);
        #1;
        chk("hold_ex2_ready", iss_ready, 0);
        chk("hold_ex2_cmt", done_cmt, 6'd30);
        @(negedge clk);
        commit_valid = 1'b1;
        commit_id    = 6'd30;
        #1;
        chk("hold_wait_ready", iss_ready, 0);
        chk("hold_wr_data", csr_wr_data, 64'h99);
        exp_wait++;
        csr_ref[7] = 64'h99;
        @(negedge clk);
        commit_valid = 1'b0;
        #1 chk("hold_idle_ready", iss_ready, 1);
        exp_issue++;
        @(negedge clk);
        iss_valid = 1'b0;
        #1 chk("hold_b_addr", csr_rd_addr, b_addr);
        @(negedge clk);
        #1;
        chk("hold_b_done_cmt", done_cmt, 6'd31);
        chk("hold_b_phy_data", phy_data, csr_ref[8]);
        @(negedge clk);
        #1 chk("hold_b_idle", iss_ready, 1);

        // reset in the middle of an op
        @(negedge clk);
        drive_issue(0, 12'h009, 64'h1, 1, 1, 7'd1, 6'd40, 4'b0001);
        @(negedge clk);
        iss_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_ready", iss_ready, 1);
        chk("midrst_rd_addr", csr_rd_addr, 0);
        chk("midrst_done", done_valid, 0);
        exp_issue = 0;
        exp_wait  = 0;
        @(negedge clk);
        rst_n        = 1'b1;
        commit_valid = 1'b1;
        commit_id    = 6'd40;
        #1 chk("midrst_no_wr", csr_wr_valid, 0);

        for (int n = 0; n < 40; n++) begin
            r_addr = 12'($urandom);
            run_op(int'($urandom_range(0, 3)), r_addr, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom),
                   6'($urandom), 4'(1 << $urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        commit_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("csr_file_%0d", i), csr_dev[i], csr_ref[i]);

`ifdef SCARIV_CSU_PERF_CNT_EN
        chk("perf_issue", perf_issue, 32'(exp_issue));
        chk("perf_wait", perf_wait, 32'(exp_wait));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
